seven_segment_reader: RTL and testbench

SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

---
 rtl/seven_segment_reader_pkg.sv | 30 +++
 rtl/seven_segment_reader_seg_to_hex.sv | 35 +++
 rtl/seven_segment_reader.sv | 138 +++++++++++++
 tb/tb_seven_segment_reader.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seven_segment_reader_pkg.sv
// Shared types and constants for the seven-segment reader: FSM state encoding
// and the active-low segment patterns for hex digits 0..F.
package seven_segment_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT_RELEASE
  } state_t;

  // seg[6:0] = {g,f,e,d,c,b,a}, a lit segment reads as 0
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seven_segment_reader_seg_to_hex.sv
// Combinational decoder from an active-low seven-segment pattern to a hex
// nibble; valid is low for any pattern that is not one of the 16 digits.
module seg_to_hex
  import seven_segment_reader_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b1;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Debounces a strobed seven-segment digit stream, pairs digits into bytes
// (high nibble first) and holds each byte until a valid/ready handshake.
// Optional error counter output enabled by SEVEN_SEGMENT_READER_ERRCNT_EN.
module seven_segment_reader
  import seven_segment_reader_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seg_a,
  input  logic       seg_b,
  input  logic       seg_c,
  input  logic       seg_d,
  input  logic       seg_e,
  input  logic       seg_f,
  input  logic       seg_g,
  input  logic       strobe,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       pat_err,
  output logic       overrun
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  logic [6:0] seg;
  assign seg = {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};

  state_t     state_reg;
  logic [7:0] cnt_reg;
  logic [6:0] ref_reg;
  logic       half_reg;
  logic [3:0] high_reg;

  logic [3:0] ref_nibble;
  logic       ref_valid;

  // Acceptance only fires while seg matches ref, so decoding ref is equivalent
  seg_to_hex u_seg_to_hex (
    .seg    (ref_reg),
    .nibble (ref_nibble),
    .valid  (ref_valid)
  );

  logic [7:0] cnt_inc;
  logic       accept;
  logic       byte_done;
  logic       handshake;
  logic       drop;

  assign cnt_inc   = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
  assign accept    = (state_reg == ST_SETTLE) && strobe && (seg == ref_reg) &&
                     (cnt_inc >= STABLE_LIMIT);
  assign byte_done = accept && ref_valid && half_reg;
  assign handshake = byte_valid && byte_ready;
  assign drop      = byte_done && byte_valid && !byte_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
      ref_reg   <= SEG_BLANK;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (strobe) begin
            ref_reg   <= seg;
            cnt_reg   <= 8'd1;
            state_reg <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!strobe) begin
            state_reg <= ST_IDLE;
          end else if (seg != ref_reg) begin
            ref_reg <= seg;
            cnt_reg <= 8'd1;
          end else begin
            cnt_reg <= cnt_inc;
            if (accept) state_reg <= ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (!strobe) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_reg   <= 1'b0;
      high_reg   <= 4'h0;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      pat_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pat_err <= accept && !ref_valid;
      if (accept) begin
        if (!ref_valid) begin
          half_reg <= 1'b0;
        end else if (!half_reg) begin
          high_reg <= ref_nibble;
          half_reg <= 1'b1;
        end else begin
          half_reg <= 1'b0;
        end
      end
      // A completed byte may replace the held one only if it is being taken now
      if (byte_done && (!byte_valid || byte_ready)) begin
        byte_data  <= {high_reg, ref_nibble};
        byte_valid <= 1'b1;
      end else if (handshake) begin
        byte_valid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
    end
  end

`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (((accept && !ref_valid) || drop) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader with STABLE_CYCLES=4: digit pairing,
// debounce, invalid patterns, overrun, simultaneous handshake and reset.
module tb_seven_segment_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_drv = 7'h7F;
  logic       strobe = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       pat_err;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seven_segment_reader #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_a      (seg_drv[0]),
    .seg_b      (seg_drv[1]),
    .seg_c      (seg_drv[2]),
    .seg_d      (seg_drv[3]),
    .seg_e      (seg_drv[4]),
    .seg_f      (seg_drv[5]),
    .seg_g      (seg_drv[6]),
    .strobe     (strobe),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .pat_err    (pat_err),
    .overrun    (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Hold pattern p with strobe high for n rising edges; ends on a negedge
  task automatic present(input logic [6:0] p, input int n);
    strobe  = 1'b1;
    seg_drv = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic release_strobe();
    strobe  = 1'b0;
    seg_drv = 7'h7F;
    @(negedge clk);
  endtask

  task automatic digit(input logic [6:0] p);
    present(p, 4);
    release_strobe();
  endtask

  task automatic consume();
    byte_ready = 1'b1;
    @(negedge clk);
    byte_ready = 1'b0;
  endtask

  initial begin
    #1;
    check_eq("rst_valid", {31'd0, byte_valid}, 32'd0);
    check_eq("rst_data", {24'd0, byte_data}, 32'h00);
    check_eq("rst_pat_err", {31'd0, pat_err}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2 then 9
    digit(7'h24);
    check_eq("hi_only_valid", {31'd0, byte_valid}, 32'd0);
    digit(7'h10);
    check_eq("b29_valid", {31'd0, byte_valid}, 32'd1);
    check_eq("b29_data", {24'd0, byte_data}, 32'h29);
    consume();
    check_eq("b29_consumed", {31'd0, byte_valid}, 32'd0);

    // 2 held only 2 cycles, then 3 stable: only 3 is taken
    present(7'h24, 2);
    present(7'h30, 4);
    release_strobe();
    digit(7'h10);
    check_eq("b39_data", {24'd0, byte_data}, 32'h39);
    consume();

    // 3 cycles is too short; a 10-cycle hold is accepted once
    present(7'h40, 3);
    release_strobe();
    present(7'h79, 10);
    release_strobe();
    check_eq("hold_once_valid", {31'd0, byte_valid}, 32'd0);
    digit(7'h24);
    check_eq("b12_hold_data", {24'd0, byte_data}, 32'h12);
    consume();

    // A, then blank pattern accepted -> error, A discarded
    digit(7'h08);
    present(7'h7F, 4);
    check_eq("pat_err_pulse", {31'd0, pat_err}, 32'd1);
    release_strobe();
    check_eq("pat_err_clear", {31'd0, pat_err}, 32'd0);
    digit(7'h79);
    check_eq("after_err_hi_valid", {31'd0, byte_valid}, 32'd0);
    digit(7'h24);
    check_eq("after_err_data", {24'd0, byte_data}, 32'h12);
    consume();

    // Overrun: 55 pending, AA completes
    digit(7'h12);
    digit(7'h12);
    check_eq("b55_data", {24'd0, byte_data}, 32'h55);
    check_eq("pre_overrun", {31'd0, overrun}, 32'd0);
    digit(7'h08);
    digit(7'h08);
    check_eq("overrun_set", {31'd0, overrun}, 32'd1);
    check_eq("overrun_held", {24'd0, byte_data}, 32'h55);
    consume();
    check_eq("overrun_dropped", {31'd0, byte_valid}, 32'd0);
    check_eq("overrun_sticky", {31'd0, overrun}, 32'd1);

    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst2_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 12 pending; 34 completes in the same cycle the consumer takes 12
    digit(7'h79);
    digit(7'h24);
    digit(7'h30);
    present(7'h19, 3);
    byte_ready = 1'b1;
    @(negedge clk);
    byte_ready = 1'b0;
    check_eq("b34_valid", {31'd0, byte_valid}, 32'd1);
    check_eq("b34_data", {24'd0, byte_data}, 32'h34);
    check_eq("b34_no_overrun", {31'd0, overrun}, 32'd0);
    release_strobe();
    consume();
    check_eq("b34_consumed", {31'd0, byte_valid}, 32'd0);

    // Reset after high nibble 7 discards it
    digit(7'h78);
    rst_n = 1'b0;
    #1;
    check_eq("rst3_valid", {31'd0, byte_valid}, 32'd0);
    check_eq("rst3_data", {24'd0, byte_data}, 32'h00);
    check_eq("rst3_pat_err", {31'd0, pat_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    digit(7'h40);
    check_eq("rst3_hi_valid", {31'd0, byte_valid}, 32'd0);
    digit(7'h79);
    check_eq("b01_valid", {31'd0, byte_valid}, 32'd1);
    check_eq("b01_data", {24'd0, byte_data}, 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
